// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Drain end of the parallel FFT datapath. A 32-point frame arrives as 8 beats
// of 4 parallel complex lanes. It is captured into one bank of a ping-pong
// register bank and streamed out one complex sample per cycle in transposed
// order (k = 8*lane + beat), under a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_signal_0..3           lanes 0..3 of the current beat, {real, imag}
//   i_valid, i_last         beat qualifier / final (8th) beat of a frame
//   i_ready                 downstream accepts o_data this cycle
//   o_data, o_valid         current output sample (0 when not valid)
//   o_last, o_index         sample 31 marker / sample index k
//   o_in_ready              next beat would be stored
//   o_overflow              sticky: a beat was dropped for lack of a free bank
//   o_frame_err             one-cycle pulse on a frame length violation
module fft_frame_serializer #(
  parameter int NB_DATA = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2*NB_DATA-1:0] i_signal_0,
  input  logic [2*NB_DATA-1:0] i_signal_1,
  input  logic [2*NB_DATA-1:0] i_signal_2,
  input  logic [2*NB_DATA-1:0] i_signal_3,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic                 i_ready,
  output logic [2*NB_DATA-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_last,
  output logic [4:0]           o_index,
  output logic                 o_in_ready,
  output logic                 o_overflow,
  output logic                 o_frame_err
);

  localparam int W = 2 * NB_DATA;

  typedef enum logic {
    WR_RECV,
    WR_DROP
  } wr_state_t;

  logic [W-1:0] mem [2][8][4];
  logic [W-1:0] lanes [4];

  logic [1:0] full;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  wr_state_t  wr_state, wr_state_n;
  logic       wr_bank, wr_bank_n;
  logic [2:0] wr_beat, wr_beat_n;
  logic       store;
  logic       overflow, overflow_n;
  logic       frame_err, frame_err_n;

  logic       rd_bank;
  logic [4:0] rd_idx;
  logic       valid;
  logic       xfer;

  assign lanes[0] = i_signal_0;
  assign lanes[1] = i_signal_1;
  assign lanes[2] = i_signal_2;
  assign lanes[3] = i_signal_3;

  // Write side next state. A bank can only be set full by a write when it is
  // free, and only cleared by the reader when it is full, so set/clear never
  // target the same bank in the same cycle.
  always_comb begin
    wr_state_n  = wr_state;
    wr_bank_n   = wr_bank;
    wr_beat_n   = wr_beat;
    full_set    = '0;
    store       = 1'b0;
    overflow_n  = overflow;
    frame_err_n = 1'b0;
    if (i_valid) begin
      if (wr_state == WR_DROP) begin
        if (i_last) begin
          wr_state_n = WR_RECV;
          wr_beat_n  = '0;
        end
      end else if (full[wr_bank]) begin
        overflow_n = 1'b1;
        if (!i_last) wr_state_n = WR_DROP;
        else         wr_beat_n  = '0;
      end else begin
        store = 1'b1;
        if (wr_beat == 3'd7 && i_last) begin
          full_set[wr_bank] = 1'b1;
          wr_bank_n         = ~wr_bank;
          wr_beat_n         = '0;
        end else if (i_last) begin
          frame_err_n = 1'b1;
          wr_beat_n   = '0;
        end else if (wr_beat == 3'd7) begin
          frame_err_n = 1'b1;
          wr_beat_n   = '0;
          wr_state_n  = WR_DROP;
        end else begin
          wr_beat_n = wr_beat + 3'd1;
        end
      end
    end
  end

  // Read side
  assign valid = full[rd_bank];
  assign xfer  = valid & i_ready;

  always_comb begin
    full_clr = '0;
    if (xfer && rd_idx == 5'd31) full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state  <= WR_RECV;
      wr_bank   <= 1'b0;
      wr_beat   <= '0;
      full      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
    end else begin
      wr_state  <= wr_state_n;
      wr_bank   <= wr_bank_n;
      wr_beat   <= wr_beat_n;
      full      <= (full | full_set) & ~full_clr;
      overflow  <= overflow_n;
      frame_err <= frame_err_n;
      if (xfer) begin
        // rd_idx wraps 31 -> 0 naturally at the bank switch
        rd_idx <= rd_idx + 5'd1;
        if (rd_idx == 5'd31) rd_bank <= ~rd_bank;
      end
    end
  end

  // Sample storage needs no reset: contents are only visible while full.
  always_ff @(posedge i_clk) begin
    if (store) begin
      for (int unsigned l = 0; l < 4; l++) begin
        mem[wr_bank][wr_beat][l] <= lanes[l];
      end
    end
  end

  assign o_valid     = valid;
  assign o_data      = valid ? mem[rd_bank][rd_idx[2:0]][rd_idx[4:3]] : '0;
  assign o_index     = valid ? rd_idx : '0;
  assign o_last      = valid && (rd_idx == 5'd31);
  assign o_in_ready  = !full[wr_bank] && (wr_state == WR_RECV);
  assign o_overflow  = overflow;
  assign o_frame_err = frame_err;

endmodule
